// File: rtl/mux4_rr_scheduler_pkg.sv
// mux_sched_pkg: shared sizes, FSM states and grant encoding for the 4-way round-robin mux scheduler
package mux_sched_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, GRANT} state_t;
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// mux4_rr_scheduler_if: requester/mux bundle; master drives en/req/data_in, slave returns sel/gnt/dout/dout_valid/slot_done
interface mux4_rr_scheduler_if;
    import mux_sched_pkg::*;
    logic en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] data_in;
    logic [SEL_W-1:0] sel;
    logic [NUM_REQ-1:0] gnt;
    logic dout;
    logic dout_valid;
    logic slot_done;
    modport master(output en, req, data_in, input sel, gnt, dout, dout_valid, slot_done);
    modport slave(input en, req, data_in, output sel, gnt, dout, dout_valid, slot_done);
endinterface

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
// rr_pick4: combinational round-robin pick; req/last in, idx = first requester after last (wrapping, last itself checked last), any = |req
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);
    always_comb begin
        idx = last;
        any = |req;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[SEL_W'(32'(last) + k)]) idx = SEL_W'(32'(last) + k);
    end
endmodule

// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler: round-robin owner of a shared 4:1 mux bit with bounded slots
// clk/rst: clock and sync active-high reset
// bus (slave): en/req/data_in in; sel/gnt grant, dout/dout_valid registered mux bit, slot_done end-of-slot pulse
module mux4_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    mux4_rr_scheduler_if.slave bus
);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] last, base, pick;
    logic any, slot_end;
    // at a slot boundary the pointer must already reflect the finishing grantee
    assign base = (state == GRANT) ? bus.sel : last;
    assign slot_end = cnt == CNT_W'(SLOT_CYCLES - 1) || !bus.req[bus.sel] || !bus.en;
    rr_pick4 u_pick (.req(bus.req), .last(base), .idx(pick), .any(any));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.sel <= '0;
            bus.gnt <= '0;
            cnt <= '0;
            last <= 2'd3;
            bus.dout <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.slot_done <= 1'b0;
        end else if (state == IDLE) begin
            bus.dout_valid <= 1'b0;
            bus.slot_done <= 1'b0;
            if (bus.en && any) begin
                state <= GRANT;
                bus.sel <= pick;
                bus.gnt <= onehot4(pick);
                cnt <= '0;
            end
        end else begin
            bus.dout <= bus.data_in[bus.sel];
            bus.dout_valid <= bus.req[bus.sel];
            bus.slot_done <= slot_end;
            cnt <= cnt + 1'b1;
            if (slot_end) begin
                last <= bus.sel;
                if (bus.en && any) begin
                    bus.sel <= pick;
                    bus.gnt <= onehot4(pick);
                    cnt <= '0;
                end else begin
                    state <= IDLE;
                    bus.gnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// tb_mux4_rr_scheduler: two schedulers (slot 4 and slot 1) against a per-cycle behavioural model plus literal pins
module tb_mux4_rr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mux4_rr_scheduler_if a ();
    mux4_rr_scheduler_if b ();
    mux4_rr_scheduler #(.SLOT_CYCLES(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    mux4_rr_scheduler #(.SLOT_CYCLES(1), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    typedef struct {
        bit busy;
        int sel;
        int cnt;
        int last;
        bit dout;
        bit dv;
        bit sd;
    } m_t;
    m_t ma, mb;
    bit live = 1'b0;
    int errs = 0;
    int checks = 0;
    function automatic int pick(logic [3:0] req, int last);
        for (int k = 1; k <= 4; k++)
            if (req[(last + k) % 4]) return (last + k) % 4;
        return last;
    endfunction
    function automatic m_t step(m_t s, logic r, logic en, logic [3:0] req, logic [3:0] d, int slot);
        m_t n = s;
        if (r) begin
            n = '{busy: 0, sel: 0, cnt: 0, last: 3, dout: 0, dv: 0, sd: 0};
            return n;
        end
        n.dv = 0;
        n.sd = 0;
        if (s.busy) begin
            n.dout = d[s.sel];
            n.dv = req[s.sel];
            n.cnt = s.cnt + 1;
            if (s.cnt == slot - 1 || !req[s.sel] || !en) begin
                n.sd = 1;
                n.last = s.sel;
                n.busy = 0;
            end
        end
        if (!n.busy && en && req != 0) begin
            n.busy = 1;
            n.sel = pick(req, n.last);
            n.cnt = 0;
        end
        return n;
    endfunction
    always @(posedge clk) begin
        ma <= step(ma, rst, a.en, a.req, a.data_in, 4);
        mb <= step(mb, rst, b.en, b.req, b.data_in, 1);
    end
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cmp(string n, logic [1:0] sel, logic [3:0] gnt, logic dout, logic dv, logic sd, m_t m);
        check({n, ".sel"}, 32'(sel), m.sel);
        check({n, ".gnt"}, 32'(gnt), m.busy ? (32'd1 << m.sel) : 32'd0);
        check({n, ".dout"}, 32'(dout), 32'(m.dout));
        check({n, ".dout_valid"}, 32'(dv), 32'(m.dv));
        check({n, ".slot_done"}, 32'(sd), 32'(m.sd));
        check({n, ".gnt_onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask
    always @(negedge clk)
        if (live) begin
            cmp("a", a.sel, a.gnt, a.dout, a.dout_valid, a.slot_done, ma);
            cmp("b", b.sel, b.gnt, b.dout, b.dout_valid, b.slot_done, mb);
        end
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic drive(logic en, logic [3:0] req, logic [3:0] d);
        a.en = en;
        a.req = req;
        a.data_in = d;
        b.en = en;
        b.req = req;
        b.data_in = d;
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask
    initial begin
        drive(1'b1, 4'b0000, 4'b0000);
        rst = 1'b1;
        cyc(2);
        live = 1'b1;
        rst = 1'b0;
        cyc(5);
        check("idle.gnt", 32'(a.gnt), 0);
        check("idle.sel", 32'(a.sel), 0);
        check("idle.dv", 32'(a.dout_valid), 0);
        check("idle.sd", 32'(a.slot_done), 0);
        drive(1'b1, 4'b1111, 4'b0101);
        cyc(5);
        check("cont.sel1", 32'(a.sel), 1);
        check("cont.sd1", 32'(a.slot_done), 1);
        check("cont.dout1", 32'(a.dout), 1);
        check("cont.dv1", 32'(a.dout_valid), 1);
        check("cont1.sel", 32'(b.sel), 0);
        check("cont1.sd", 32'(b.slot_done), 1);
        cyc(4);
        check("cont.sel2", 32'(a.sel), 2);
        check("cont.sd2", 32'(a.slot_done), 1);
        check("cont.dout2", 32'(a.dout), 0);
        cyc(11);
        drive(1'b1, 4'b0000, 4'b0000);
        cyc(3);
        drive(1'b1, 4'b0100, 4'b0100);
        pulse_rst();
        cyc(3);
        check("rel.sel", 32'(a.sel), 2);
        check("rel.dout", 32'(a.dout), 1);
        drive(1'b1, 4'b0000, 4'b0100);
        cyc(1);
        check("rel.sd", 32'(a.slot_done), 1);
        check("rel.dv", 32'(a.dout_valid), 0);
        check("rel.gnt", 32'(a.gnt), 0);
        drive(1'b1, 4'b0001, 4'b0001);
        cyc(1);
        check("rel.next_sel", 32'(a.sel), 0);
        check("rel.next_gnt", 32'(a.gnt), 1);
        cyc(2);
        drive(1'b1, 4'b0000, 4'b0000);
        cyc(2);
        drive(1'b1, 4'b1000, 4'b1000);
        pulse_rst();
        cyc(5);
        check("one.sel", 32'(a.sel), 3);
        check("one.sd", 32'(a.slot_done), 1);
        check("one.dv", 32'(a.dout_valid), 1);
        check("one.dout", 32'(a.dout), 1);
        cyc(1);
        check("one.sd_low", 32'(a.slot_done), 0);
        check("one.dv_cont", 32'(a.dout_valid), 1);
        check("one.sel2", 32'(a.sel), 3);
        cyc(4);
        drive(1'b1, 4'b0000, 4'b0000);
        cyc(3);
        drive(1'b1, 4'b0010, 4'b0010);
        pulse_rst();
        cyc(2);
        drive(1'b0, 4'b0010, 4'b0010);
        cyc(1);
        check("en.sd", 32'(a.slot_done), 1);
        check("en.gnt", 32'(a.gnt), 0);
        check("en.dv", 32'(a.dout_valid), 1);
        cyc(3);
        check("en.hold_gnt", 32'(a.gnt), 0);
        check("en.hold_dv", 32'(a.dout_valid), 0);
        drive(1'b1, 4'b0010, 4'b0010);
        cyc(1);
        check("en.regnt", 32'(a.gnt), 2);
        drive(1'b1, 4'b1111, 4'b1111);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("rst.gnt", 32'(a.gnt), 0);
        check("rst.sel", 32'(a.sel), 0);
        check("rst.dout", 32'(a.dout), 0);
        check("rst.dv", 32'(a.dout_valid), 0);
        check("rst.sd", 32'(a.slot_done), 0);
        rst = 1'b0;
        cyc(1);
        check("rst.first_gnt", 32'(a.gnt), 1);
        drive(1'b1, 4'b0110, 4'b0110);
        pulse_rst();
        cyc(1);
        check("s1.sel_a", 32'(b.sel), 1);
        check("s1.sd_a", 32'(b.slot_done), 0);
        cyc(1);
        check("s1.sel_b", 32'(b.sel), 2);
        check("s1.sd_b", 32'(b.slot_done), 1);
        check("s1.dout_b", 32'(b.dout), 1);
        cyc(1);
        check("s1.sel_c", 32'(b.sel), 1);
        check("s1.sd_c", 32'(b.slot_done), 1);
        cyc(5);
        drive(1'b1, 4'b0000, 4'b0000);
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
